// File: rtl/posit_alu_issue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// posit_alu_issue : command FIFO + registered result stage around an 8-bit
//                   combinational posit ALU, valid/ready on both sides.
// Revision: 1.0
// ---------------------------------------------------------------------------
module posit_alu_issue #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [7:0]                    in_a,
  input  logic [7:0]                    in_b,
  input  logic [2:0]                    in_op,
  output logic [7:0]                    alu_a,
  output logic [7:0]                    alu_b,
  output logic [2:0]                    alu_sel,
  input  logic [7:0]                    alu_result,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    out_result,
  output logic [2:0]                    out_op,
  output logic                          out_illegal,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   op_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [2:0] LAST_LEGAL_OP = 3'd4;

  logic [18:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [18:0]      head;
  logic             empty;
  logic             push;
  logic             issue;
  logic             head_illegal;

  assign empty        = (count == '0);
  assign head         = empty ? 19'd0 : mem[rd_ptr];
  assign alu_a        = head[18:11];
  assign alu_b        = head[10:3];
  assign alu_sel      = head[2:0];
  assign head_illegal = (alu_sel > LAST_LEGAL_OP);

  // in_ready is built only from registered state and the flush input.
  assign in_ready   = (count < DEPTH_C) && !flush;
  assign push       = in_valid && in_ready;
  assign issue      = !empty && (!out_valid || out_ready);
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_a, in_b, in_op};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (issue) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, issue})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_result  <= 8'h00;
      out_op      <= 3'b000;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (issue) begin
      out_valid   <= 1'b1;
      out_result  <= head_illegal ? 8'h00 : alu_result;
      out_op      <= alu_sel;
      out_illegal <= head_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Handshakes are counted even in a flush cycle: downstream saw them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= 16'h0000;
    end else if (out_valid && out_ready) begin
      op_count <= op_count + 16'h0001;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_posit_alu_issue.sv
`default_nettype none
// tb_posit_alu_issue : queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_posit_alu_issue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = 8'h00;
  logic [7:0]  in_b = 8'h00;
  logic [2:0]  in_op = 3'b000;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_sel;
  logic [7:0]  alu_result;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_result;
  logic [2:0]  out_op;
  logic        out_illegal;
  logic [2:0]  fifo_count;
  logic [15:0] op_count;

  int checks = 0;
  int errors = 0;

  posit_alu_issue #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_op(out_op), .out_illegal(out_illegal),
    .fifo_count(fifo_count), .op_count(op_count)
  );

  assign alu_result = alu_a ^ alu_b;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: command queue plus one output slot.
  cmd_t        mq[$];
  logic        m_valid = 1'b0;
  logic [7:0]  m_res = 8'h00;
  logic [2:0]  m_op = 3'b000;
  logic        m_ill = 1'b0;
  logic [15:0] m_opcnt = 16'h0000;
  logic [7:0]  got[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_valid = 1'b0;
      m_res   = 8'h00;
      m_op    = 3'b000;
      m_ill   = 1'b0;
      m_opcnt = 16'h0000;
    end else begin
      logic accept;
      logic handshake;
      logic take;
      cmd_t c;
      accept    = (mq.size() < DEPTH) && !flush && in_valid;
      handshake = m_valid && out_ready;
      take      = (mq.size() != 0) && (!m_valid || out_ready);
      if (handshake) m_opcnt = m_opcnt + 16'h0001;
      if (flush) begin
        mq.delete();
        m_valid = 1'b0;
      end else begin
        if (take) begin
          c = mq.pop_front();
          m_valid = 1'b1;
          m_op    = c.op;
          m_ill   = (c.op >= 3'd5);
          m_res   = m_ill ? 8'h00 : (c.a ^ c.b);
        end else if (handshake) begin
          m_valid = 1'b0;
        end
        if (accept) mq.push_back('{a: in_a, b: in_b, op: in_op});
      end
    end
  end

  always @(negedge clk) begin
    cmd_t h;
    h = (mq.size() != 0) ? mq[0] : '0;
    chk("in_ready",    {31'd0, in_ready},    {31'd0, (mq.size() < DEPTH) && !flush});
    chk("fifo_count",  {29'd0, fifo_count},  mq.size());
    chk("alu_a",       {24'd0, alu_a},       {24'd0, h.a});
    chk("alu_b",       {24'd0, alu_b},       {24'd0, h.b});
    chk("alu_sel",     {29'd0, alu_sel},     {29'd0, h.op});
    chk("out_valid",   {31'd0, out_valid},   {31'd0, m_valid});
    chk("out_result",  {24'd0, out_result},  {24'd0, m_res});
    chk("out_op",      {29'd0, out_op},      {29'd0, m_op});
    chk("out_illegal", {31'd0, out_illegal}, {31'd0, m_ill});
    chk("op_count",    {16'd0, op_count},    {16'd0, m_opcnt});
    if (out_valid && out_ready) got.push_back(out_result);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_op = op;
    step();
  endtask

  logic [7:0]  sa [8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
  logic [7:0]  se [8] = '{8'h0E, 8'h2C, 8'h4A, 8'h68, 8'h86, 8'hA4, 8'hC2, 8'hE0};
  logic [7:0]  ba [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic [7:0]  be [5] = '{8'h91, 8'hA2, 8'hB3, 8'hC4, 8'hD5};
  logic [15:0] op_before;
  int          max_cnt;

  initial begin
    #3;
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst fifo_count", {29'd0, fifo_count}, 32'd0);
    chk("rst op_count", {16'd0, op_count}, 32'd0);
    chk("rst out_result", {24'd0, out_result}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Single command: valid two edges after accept.
    out_ready = 1'b1;
    send(8'h48, 8'h30, 3'b000);
    in_valid = 1'b0;
    chk("single early valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("single valid", {31'd0, out_valid}, 32'd1);
    chk("single result", {24'd0, out_result}, 32'h78);
    chk("single op", {29'd0, out_op}, 32'd0);
    chk("single illegal", {31'd0, out_illegal}, 32'd0);
    step();
    chk("single op_count", {16'd0, op_count}, 32'd1);

    // Streaming at full rate.
    got.delete();
    max_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      send(sa[i], 8'h0F, 3'(i % 5));
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    end
    in_valid = 1'b0;
    step(); step(); step();
    chk("stream max count", max_cnt, 32'd1);
    chk("stream n results", got.size(), 32'd8);
    for (int i = 0; i < 8; i++) chk("stream result", (i < got.size()) ? {24'd0, got[i]} : 32'hFFFF, {24'd0, se[i]});
    chk("stream op_count", {16'd0, op_count}, 32'd9);

    // Backpressure until full, sixth push refused.
    out_ready = 1'b0;
    got.delete();
    for (int i = 0; i < 6; i++) send(ba[i], 8'h80, 3'(i % 5));
    in_valid = 1'b0;
    chk("bp fifo_count", {29'd0, fifo_count}, 32'd4);
    chk("bp in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp held result", {24'd0, out_result}, 32'h91);
    step(); step();
    chk("bp stable result", {24'd0, out_result}, 32'h91);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("bp n results", got.size(), 32'd5);
    for (int i = 0; i < 5; i++) chk("bp result", (i < got.size()) ? {24'd0, got[i]} : 32'hFFFF, {24'd0, be[i]});

    // Illegal opcode.
    send(8'hFF, 8'h0F, 3'b110);
    in_valid = 1'b0;
    step();
    chk("illegal result", {24'd0, out_result}, 32'h00);
    chk("illegal flag", {31'd0, out_illegal}, 32'd1);
    chk("illegal op", {29'd0, out_op}, 32'd6);
    step();

    // Flush with three queued and one valid output.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(ba[i], 8'h01, 3'b010);
    chk("pre-flush count", {29'd0, fifo_count}, 32'd3);
    chk("pre-flush valid", {31'd0, out_valid}, 32'd1);
    op_before = op_count;
    flush = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("flush in_ready", {31'd0, in_ready}, 32'd0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush count", {29'd0, fifo_count}, 32'd0);
    chk("flush valid", {31'd0, out_valid}, 32'd0);
    chk("flush op_count", {16'd0, op_count}, {16'd0, op_before});
    step();

    // Asynchronous reset mid-stream.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(sa[i], 8'h55, 3'b001);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("arst out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst fifo_count", {29'd0, fifo_count}, 32'd0);
    chk("arst in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst out_result", {24'd0, out_result}, 32'd0);
    chk("arst alu_a", {24'd0, alu_a}, 32'd0);
    chk("arst op_count", {16'd0, op_count}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // op_count wrap: 65537 handshakes from zero.
    for (int i = 0; i < 65537; i++) send(8'h5A, 8'hA5, 3'b011);
    in_valid = 1'b0;
    step(); step();
    chk("wrap op_count", {16'd0, op_count}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
